// File: rtl/vote_pkg.sv
// vote_pkg: shared constants for the voting machine core
package vote_pkg;
    localparam int NUM_CAND = 4;
    localparam logic [2:0] SYM_DASH = 3'd5;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_1 = 7'b0000110;
    localparam logic [6:0] SEG_2 = 7'b1011011;
    localparam logic [6:0] SEG_3 = 7'b1001111;
    localparam logic [6:0] SEG_4 = 7'b1100110;
    localparam logic [6:0] SEG_DASH = 7'b1000000;
    localparam logic [2:0] RGB_OFF = 3'b000;
    localparam logic [2:0] RGB_SEL = 3'b001;
    localparam logic [2:0] RGB_OK = 3'b010;
    localparam logic [2:0] RGB_ERR = 3'b100;
    localparam logic [2:0] RGB_WIN = 3'b011;
    localparam logic [2:0] RGB_TIE = 3'b110;
endpackage

// File: rtl/seg7_dec.sv
// seg7_dec: symbol (0 blank, 1-4 candidate, 5 dash) to 7-segment pattern
module seg7_dec
    import vote_pkg::*;
(
    input  logic [2:0] sym,
    output logic [6:0] seg
);
    always_comb
        seg = sym == 3'd1 ? SEG_1 :
              sym == 3'd2 ? SEG_2 :
              sym == 3'd3 ? SEG_3 :
              sym == 3'd4 ? SEG_4 :
              sym == SYM_DASH ? SEG_DASH : SEG_BLANK;
endmodule

// File: rtl/vote_evm.sv
// vote_evm: four-candidate voting machine with saturating tallies and winner display
module vote_evm
    import vote_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       b1,
    input  logic       b2,
    input  logic       b3,
    input  logic       b4,
    input  logic       s1,
    input  logic       s2,
    output logic       l1,
    output logic       l2,
    output logic       l3,
    output logic       l4,
    output logic [2:0] rgb,
    output logic       c0,
    output logic [6:0] show
);
    logic [CNT_W-1:0] tally [NUM_CAND];
    logic [CNT_W-1:0] mx;
    logic [3:0] b;
    logic [2:0] sel, sel_n, bidx, cnt, win, sym, rgb_n;
    logic [1:0] si, si_n;
    logic s1_d, res_d, one, inc, c0_n;
    logic [6:0] seg;
    assign b = {b4, b3, b2, b1};
    assign one = (b != 4'd0) && ((b & (b - 4'd1)) == 4'd0);
    assign bidx = b[0] ? 3'd1 : b[1] ? 3'd2 : b[2] ? 3'd3 : 3'd4;
    assign si = 2'(sel - 3'd1);
    assign si_n = 2'(sel_n - 3'd1);
    always_comb begin
        mx = tally[0];
        for (int i = 1; i < NUM_CAND; i++)
            if (tally[i] > mx) mx = tally[i];
        cnt = 3'd0;
        win = 3'd0;
        for (int i = 0; i < NUM_CAND; i++)
            if (tally[i] == mx) begin
                cnt = cnt + 3'd1;
                win = 3'(i + 1);
            end
    end
    always_comb begin
        inc = 1'b0;
        c0_n = 1'b0;
        sel_n = sel;
        rgb_n = res_d ? RGB_OFF : rgb;
        if (s2) begin
            sel_n = 3'd0;
            rgb_n = cnt == 3'd1 ? RGB_WIN : RGB_TIE;
        end else if (s1 && !s1_d) begin
            inc = sel != 3'd0;
            c0_n = sel != 3'd0;
            sel_n = 3'd0;
            rgb_n = sel != 3'd0 ? RGB_OK : RGB_ERR;
        end else if (one) begin
            sel_n = bidx;
            rgb_n = RGB_SEL;
        end else if (b != 4'd0)
            rgb_n = RGB_ERR;
        sym = s2 ? (cnt == 3'd1 ? win : SYM_DASH) : sel_n;
    end
    seg7_dec u_dec (.sym(sym), .seg(seg));
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CAND; i++) tally[i] <= '0;
            sel <= 3'd0;
            s1_d <= 1'b0;
            res_d <= 1'b0;
            {l4, l3, l2, l1} <= 4'b0000;
            rgb <= RGB_OFF;
            c0 <= 1'b0;
            show <= SEG_BLANK;
        end else begin
            if (inc && tally[si] != '1) tally[si] <= tally[si] + CNT_W'(1);
            sel <= sel_n;
            s1_d <= s1;
            res_d <= s2;
            {l4, l3, l2, l1} <= sel_n != 3'd0 ? 4'b0001 << si_n : 4'b0000;
            rgb <= rgb_n;
            c0 <= c0_n;
            show <= seg;
        end
    end
endmodule

// File: tb/tb_vote_evm.sv
// tb_vote_evm: directed scoreboard bench for vote_evm (8-bit and 2-bit tallies)
module tb_vote_evm;
    logic clk = 1'b0, rst = 1'b1;
    logic b1 = 1'b0, b2 = 1'b0, b3 = 1'b0, b4 = 1'b0, s1 = 1'b0, s2 = 1'b0;
    logic l1, l2, l3, l4, c0, m1, m2, m3, m4, k0;
    logic [2:0] rgb, rgb2;
    logic [6:0] show, show2;
    localparam logic [6:0] BL = 7'b0000000, DASH = 7'b1000000;
    localparam logic [2:0] OFF = 3'b000, SEL = 3'b001, OK = 3'b010, ERR = 3'b100, WIN = 3'b011, TIE = 3'b110;
    logic [6:0] digs [4] = '{7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110};
    typedef struct packed {
        logic [3:0] l;
        logic [2:0] rgb;
        logic       c0;
        logic [6:0] show;
    } exp_t;
    exp_t q[$];
    int checks = 0, passed = 0;

    vote_evm #(.CNT_W(8)) u8 (.clk(clk), .rst(rst), .b1(b1), .b2(b2), .b3(b3), .b4(b4), .s1(s1), .s2(s2),
        .l1(l1), .l2(l2), .l3(l3), .l4(l4), .rgb(rgb), .c0(c0), .show(show));
    vote_evm #(.CNT_W(2)) u2 (.clk(clk), .rst(rst), .b1(b1), .b2(b2), .b3(b3), .b4(b4), .s1(s1), .s2(s2),
        .l1(m1), .l2(m2), .l3(m3), .l4(m4), .rgb(rgb2), .c0(k0), .show(show2));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) passed++;
        else $error("FAIL %s got %0h want %0h", tag, got, want);
    endtask

    task automatic step(input logic [3:0] b, input logic v1, input logic v2, input logic [3:0] el,
                        input logic [2:0] er, input logic ec, input logic [6:0] es, input string tag);
        exp_t e;
        {b4, b3, b2, b1} = b;
        s1 = v1;
        s2 = v2;
        q.push_back('{el, er, ec, es});
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk({tag, ".l"}, 32'({l4, l3, l2, l1}), 32'(e.l));
        chk({tag, ".rgb"}, 32'(rgb), 32'(e.rgb));
        chk({tag, ".c0"}, 32'(c0), 32'(e.c0));
        chk({tag, ".show"}, 32'(show), 32'(e.show));
        chk({tag, ".c0_w2"}, 32'(k0), 32'(e.c0));
    endtask

    task automatic vote(input int c);
        step(4'(1 << (c - 1)), 1'b0, 1'b0, 4'(1 << (c - 1)), SEL, 1'b0, digs[c-1], "vsel");
        step(4'b0000, 1'b1, 1'b0, 4'b0000, OK, 1'b1, BL, "vcast");
        step(4'b0000, 1'b0, 1'b0, 4'b0000, OK, 1'b0, BL, "vrel");
    endtask

    initial begin
        @(posedge clk);
        step(4'b0000, 1'b1, 1'b0, 4'b0000, OFF, 1'b0, BL, "reset");
        rst = 1'b0;
        step(4'b0001, 1'b0, 1'b0, 4'b0001, SEL, 1'b0, digs[0], "b1");
        step(4'b0000, 1'b1, 1'b0, 4'b0000, OK, 1'b1, BL, "cast1");
        step(4'b0000, 1'b0, 1'b0, 4'b0000, OK, 1'b0, BL, "c0drop");
        chk("t1", 32'(u8.tally[0]), 32'd1);
        step(4'b0010, 1'b0, 1'b0, 4'b0010, SEL, 1'b0, digs[1], "b2");
        step(4'b0000, 1'b0, 1'b0, 4'b0010, SEL, 1'b0, digs[1], "hold2");
        step(4'b0100, 1'b0, 1'b0, 4'b0100, SEL, 1'b0, digs[2], "b3");
        step(4'b0000, 1'b1, 1'b0, 4'b0000, OK, 1'b1, BL, "cast3");
        for (int i = 0; i < 9; i++) step(4'b0000, 1'b1, 1'b0, 4'b0000, OK, 1'b0, BL, "s1held");
        chk("t2", 32'(u8.tally[1]), 32'd0);
        chk("t3", 32'(u8.tally[2]), 32'd1);
        step(4'b0011, 1'b0, 1'b0, 4'b0000, ERR, 1'b0, BL, "multi_none");
        step(4'b1000, 1'b0, 1'b0, 4'b1000, SEL, 1'b0, digs[3], "b4");
        step(4'b0011, 1'b0, 1'b0, 4'b1000, ERR, 1'b0, digs[3], "multi_keep");
        step(4'b0000, 1'b0, 1'b1, 4'b0000, TIE, 1'b0, DASH, "tie11");
        step(4'b0000, 1'b0, 1'b0, 4'b0000, OFF, 1'b0, BL, "leave1");
        step(4'b0000, 1'b1, 1'b0, 4'b0000, ERR, 1'b0, BL, "cast_none");
        step(4'b0000, 1'b0, 1'b0, 4'b0000, ERR, 1'b0, BL, "hold_err");
        chk("t4", 32'(u8.tally[3]), 32'd0);
        vote(2);
        vote(2);
        step(4'b0000, 1'b0, 1'b1, 4'b0000, WIN, 1'b0, digs[1], "win2");
        step(4'b0000, 1'b1, 1'b1, 4'b0000, WIN, 1'b0, digs[1], "s1_in_res");
        step(4'b0000, 1'b0, 1'b0, 4'b0000, OFF, 1'b0, BL, "leave2");
        vote(1);
        step(4'b0000, 1'b0, 1'b1, 4'b0000, TIE, 1'b0, DASH, "tie22");
        step(4'b0001, 1'b1, 1'b1, 4'b0000, TIE, 1'b0, DASH, "ignore_res");
        chk("t1b", 32'(u8.tally[0]), 32'd2);
        rst = 1'b1;
        step(4'b0000, 1'b0, 1'b1, 4'b0000, OFF, 1'b0, BL, "rst_res");
        rst = 1'b0;
        step(4'b0000, 1'b0, 1'b1, 4'b0000, TIE, 1'b0, DASH, "zero_tie");
        step(4'b0000, 1'b0, 1'b0, 4'b0000, OFF, 1'b0, BL, "leave3");
        step(4'b0001, 1'b0, 1'b0, 4'b0001, SEL, 1'b0, digs[0], "sel_pre_rst");
        rst = 1'b1;
        step(4'b0000, 1'b1, 1'b0, 4'b0000, OFF, 1'b0, BL, "rst_cast");
        rst = 1'b0;
        chk("t1c", 32'(u8.tally[0]), 32'd0);
        step(4'b0000, 1'b0, 1'b0, 4'b0000, OFF, 1'b0, BL, "post_rst");
        for (int i = 0; i < 4; i++) vote(4);
        chk("t4_w8", 32'(u8.tally[3]), 32'd4);
        chk("t4_w2", 32'(u2.tally[3]), 32'd3);
        step(4'b0000, 1'b0, 1'b1, 4'b0000, WIN, 1'b0, digs[3], "win4");
        chk("win4_w2", 32'(show2), 32'(digs[3]));
        chk("rgb_w2", 32'(rgb2), 32'(WIN));
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
